// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with a multi-bit
// shift sequencer.
//
// Commands are issued with a start/busy/done handshake. The supported
// commands are nop, load, shift right and shift left. A shift command can
// rotate the register or take serial input at either end, and it runs for
// a programmable number of single-bit steps.
//
// Optional feature: define SHREG_ARITH_EN to add the arith_i port. When
// arith_i is latched high, a non-rotating right shift sign-extends from
// the MSB.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-low reset
//   start_i  command strobe, sampled only in IDLE
//   op_i     00 nop, 01 shift right, 10 shift left, 11 parallel load
//   rot_i    circulate end bit instead of serial input (shifts only)
//   amt_i    number of single-bit shifts
//   par_i    parallel load data
//   sir_i    serial in at MSB for right shifts
//   sil_i    serial in at LSB for left shifts
//   arith_i  (SHREG_ARITH_EN only) arithmetic right shift
//   q_o      register contents
//   sor_o    q_o[0]
//   sol_o    q_o[WIDTH-1]
//   busy_o   high while shifting
//   done_o   one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start_i; q held
// SHIFT | one single-bit shift per edge until the count runs out
// DONE  | one-cycle completion pulse; start_i ignored

module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic             rot_i,
    input  logic [CNT_W-1:0] amt_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             sir_i,
    input  logic             sil_i,
`ifdef SHREG_ARITH_EN
    input  logic             arith_i,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic             sor_o,
    output logic             sol_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             left_r, left_nxt;
    logic             rot_r, rot_nxt;
    logic             in_r, in_l;
`ifdef SHREG_ARITH_EN
    logic             arith_r, arith_nxt;
`endif

    // Bits entering each end during a shift. Rotate has priority over
    // arithmetic sign extension.
`ifdef SHREG_ARITH_EN
    assign in_r = rot_r ? q[0] : (arith_r ? q[WIDTH-1] : sir_i);
`else
    assign in_r = rot_r ? q[0] : sir_i;
`endif
    assign in_l = rot_r ? q[WIDTH-1] : sil_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            q       <= '0;
            cnt     <= '0;
            left_r  <= 1'b0;
            rot_r   <= 1'b0;
`ifdef SHREG_ARITH_EN
            arith_r <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            q       <= q_nxt;
            cnt     <= cnt_nxt;
            left_r  <= left_nxt;
            rot_r   <= rot_nxt;
`ifdef SHREG_ARITH_EN
            arith_r <= arith_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        left_nxt  = left_r;
        rot_nxt   = rot_r;
`ifdef SHREG_ARITH_EN
        arith_nxt = arith_r;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = DONE;
                    case (op_i)
                        2'b11: q_nxt = par_i;
                        2'b01, 2'b10: begin
                            // A zero-length shift completes like a nop.
                            if (amt_i != '0) begin
                                state_nxt = SHIFT;
                                cnt_nxt   = amt_i;
                                left_nxt  = (op_i == 2'b10);
                                rot_nxt   = rot_i;
`ifdef SHREG_ARITH_EN
                                arith_nxt = arith_i;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                if (left_r) begin
                    q_nxt = {q[WIDTH-2:0], in_l};
                end else begin
                    q_nxt = {in_r, q[WIDTH-1:1]};
                end
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign q_o    = q;
    assign sor_o  = q[0];
    assign sol_o  = q[WIDTH-1];
    assign busy_o = (state == SHIFT);
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [1:0]       op_i;
    logic             rot_i;
    logic [CNT_W-1:0] amt_i;
    logic [WIDTH-1:0] par_i;
    logic             sir_i;
    logic             sil_i;
`ifdef SHREG_ARITH_EN
    logic             arith_i;
`endif
    logic [WIDTH-1:0] q_o;
    logic             sor_o, sol_o, busy_o, done_o;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             sor;
        logic             sol;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .rot_i   (rot_i),
        .amt_i   (amt_i),
        .par_i   (par_i),
        .sir_i   (sir_i),
        .sil_i   (sil_i),
`ifdef SHREG_ARITH_EN
        .arith_i (arith_i),
`endif
        .q_o     (q_o),
        .sor_o   (sor_o),
        .sol_o   (sol_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b1 && done_o === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_q", 32'(q_o), 32'(e.q));
                    check("done_sor", 32'(sor_o), 32'(e.sor));
                    check("done_sol", 32'(sol_o), 32'(e.sol));
                    check("done_busy", 32'(busy_o), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] q);
        exp_t e;
        e.q   = q;
        e.sor = q[0];
        e.sol = q[WIDTH-1];
        sb.push_back(e);
    endtask

    // Issue one command; returns 1 time unit after the accept edge.
    task automatic cmd(input logic [1:0] op, input logic rot, input logic [CNT_W-1:0] amt,
                       input logic [WIDTH-1:0] par);
        op_i    = op;
        rot_i   = rot;
        amt_i   = amt;
        par_i   = par;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Bounded wait for done, then step into IDLE.
    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && done_o !== 1'b1; i++) @(negedge clk_i);
        check(name, 32'(done_o), 32'd1);
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] rot_seq [3];
        rot_seq[0] = 8'hA5;
        rot_seq[1] = 8'hD2;
        rot_seq[2] = 8'h69;
        rst_i = 1'b0; start_i = 1'b0; op_i = 2'b00; rot_i = 1'b0;
        amt_i = '0; par_i = '0; sir_i = 1'b0; sil_i = 1'b0;
`ifdef SHREG_ARITH_EN
        arith_i = 1'b0;
`endif
        #2;
        check("rst_q", 32'(q_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        tick();
        rst_i = 1'b1;
        tick();

        // Reset in the middle of a shift discards the command.
        push(8'hFF);
        cmd(2'b11, 1'b0, '0, 8'hFF);
        wait_done("load_ff");
        cmd(2'b01, 1'b0, 4'd5, '0);
        tick();
        tick();
        check("mid_shift_q", 32'(q_o), 32'h3F);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_q", 32'(q_o), 32'h0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            check("no_done_after_rst", 32'(done_o), 32'd0);
        end
        tick();

        // Load: done for exactly one cycle, never busy.
        push(8'hA5);
        cmd(2'b11, 1'b0, '0, 8'hA5);
        @(negedge clk_i);
        check("load_done", 32'(done_o), 32'd1);
        check("load_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        check("load_done_1cyc", 32'(done_o), 32'd0);
        check("load_busy2", 32'(busy_o), 32'd0);
        tick();

        // Rotate right by 3: A5 -> D2 -> 69 -> B4.
        push(8'hB4);
        cmd(2'b01, 1'b1, 4'd3, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("ror_busy", 32'(busy_o), 32'd1);
            check("ror_step_q", 32'(q_o), 32'(rot_seq[i]));
        end
        @(negedge clk_i);
        check("ror_busy_end", 32'(busy_o), 32'd0);
        tick();

        // Shift left by 2 with sil=1: 81 -> 03 -> 07.
        push(8'h81);
        cmd(2'b11, 1'b0, '0, 8'h81);
        wait_done("load_81");
        push(8'h07);
        sil_i = 1'b1;
        cmd(2'b10, 1'b0, 4'd2, '0);
        wait_done("shl_done");
        sil_i = 1'b0;

        // Start held through SHIFT and DONE is ignored: 07 -> 83 -> C1 -> E0 -> F0.
        push(8'hF0);
        sir_i = 1'b1;
        cmd(2'b01, 1'b0, 4'd4, '0);
        op_i = 2'b11; par_i = 8'h3C; rot_i = 1'b1; amt_i = 4'd1; start_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        start_i = 1'b0;
        sir_i = 1'b0;
        check("after_ignored_q", 32'(q_o), 32'hF0);
        check("after_ignored_busy", 32'(busy_o), 32'd0);
        tick();

        // Nop and zero-length shift both complete next cycle with q held.
        push(8'hF0);
        cmd(2'b00, 1'b0, 4'd3, 8'h11);
        @(negedge clk_i);
        check("nop_done", 32'(done_o), 32'd1);
        tick();
        push(8'hF0);
        cmd(2'b01, 1'b0, 4'd0, 8'h22);
        @(negedge clk_i);
        check("amt0_done", 32'(done_o), 32'd1);
        check("amt0_busy", 32'(busy_o), 32'd0);
        tick();

        // Amounts beyond WIDTH: rotate left by 9 equals rotate by 1; F0 -> E1.
        push(8'hE1);
        cmd(2'b10, 1'b1, 4'd9, '0);
        wait_done("rol9_done");
        // Non-rotating right shift by 15 with sir=1 fills with ones.
        push(8'hFF);
        sir_i = 1'b1;
        cmd(2'b01, 1'b0, 4'd15, '0);
        wait_done("shr15_done");
        sir_i = 1'b0;

`ifdef SHREG_ARITH_EN
        push(8'h80);
        cmd(2'b11, 1'b0, '0, 8'h80);
        wait_done("load_80a");
        push(8'hF0);
        arith_i = 1'b1;
        cmd(2'b01, 1'b0, 4'd3, '0);
        arith_i = 1'b0;
        wait_done("arith_done");
        push(8'h80);
        cmd(2'b11, 1'b0, '0, 8'h80);
        wait_done("load_80b");
        push(8'h10);
        cmd(2'b01, 1'b0, 4'd3, '0);
        wait_done("logic_done");
`endif

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
